wbarb08: RTL and testbench

Four-master round-robin arbiter and cycle controller for a shared 8-bit Wishbone slave bus, such as the 8-bit output-port slaves. It grants one master at a time and holds the grant for that master's whole CYC. It routes the granted master's strobe, write-enable and data to the single slave port, and returns ACK and read data. A watchdog aborts transfers the slave never acknowledges.

---
 rtl/wb08_pkg.sv | 25 ++
 rtl/wbarb08_rr.sv | 15 +
 rtl/wbarb08.sv | 124 ++++++++++++
 tb/tb_wbarb08.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb08_pkg.sv
// Shared definitions for the 8-bit Wishbone four-master arbiter:
// state encoding, master count and the rotating-priority search helper.
package wb08_pkg;

   localparam int unsigned NM = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN   = 2'd1,
      ST_ABORT = 2'd2
   } state_t;

   // Returns {any, idx}: first requester in the order p+1, p+2, p+3, p (mod 4).
   function automatic logic [2:0] rr_pick(input logic [NM-1:0] req, input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] idx;
      res = '0;
      for (int unsigned k = 1; k <= NM; k++) begin
         idx = p + k[1:0];
         if (!res[2] && req[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

endpackage

// File: rtl/wbarb08_rr.sv
// Combinational 4-way rotating priority picker; the last owner p is lowest priority.
module wbarb08_rr
   import wb08_pkg::*;
(
   input  logic [NM-1:0] req_i,
   input  logic [1:0]    p_i,
   output logic          any_o,
   output logic [1:0]    idx_o
);

   always_comb begin
      {any_o, idx_o} = rr_pick(req_i, p_i);
   end

endmodule

// File: rtl/wbarb08.sv
// Four-master round-robin arbiter and cycle controller for a shared 8-bit
// Wishbone slave, with a watchdog that aborts unacknowledged transfers.
module wbarb08
   import wb08_pkg::*;
#(
   parameter int unsigned TMO_CYCLES = 15
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic [3:0]  M_CYC_I,
   input  logic [3:0]  M_STB_I,
   input  logic [3:0]  M_WE_I,
   input  logic [31:0] M_DAT_I,
   output logic [3:0]  M_ACK_O,
   output logic [3:0]  M_ERR_O,
   output logic [7:0]  M_DAT_O,
   output logic [3:0]  GNT_O,
   output logic        S_STB_O,
   output logic        S_WE_O,
   output logic [7:0]  S_DAT_O,
   input  logic [7:0]  S_DAT_I,
   input  logic        S_ACK_I
);

   localparam logic [7:0] W_LAST = 8'(TMO_CYCLES - 1);

   state_t     state_q, state_d;
   logic [1:0] g_q, g_d;
   logic [1:0] p_q, p_d;
   logic [7:0] w_q, w_d;

   logic       rr_any;
   logic [1:0] rr_idx;
   logic       cyc_g, stb_g;

   wbarb08_rr u_rr (
      .req_i (M_CYC_I),
      .p_i   (p_q),
      .any_o (rr_any),
      .idx_o (rr_idx)
   );

   assign cyc_g   = M_CYC_I[g_q];
   assign stb_g   = M_STB_I[g_q];
   assign M_DAT_O = S_DAT_I;

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q <= ST_IDLE;
         g_q     <= '0;
         p_q     <= 2'd3;
         w_q     <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         p_q     <= p_d;
         w_q     <= w_d;
      end
   end

   // In ABORT, w doubles as the ERR-pulse flag: zero only on the first ABORT cycle.
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      p_d     = p_q;
      w_d     = w_q;
      unique case (state_q)
         ST_IDLE: begin
            if (rr_any) begin
               state_d = ST_OWN;
               g_d     = rr_idx;
               p_d     = rr_idx;
               w_d     = '0;
            end
         end
         ST_OWN: begin
            if (!cyc_g) begin
               state_d = rr_any ? ST_OWN : ST_IDLE;
               g_d     = rr_any ? rr_idx : g_q;
               p_d     = rr_any ? rr_idx : p_q;
               w_d     = '0;
            end else if (stb_g && !S_ACK_I) begin
               if (w_q == W_LAST) begin
                  state_d = ST_ABORT;
                  w_d     = '0;
               end else begin
                  w_d = w_q + 8'd1;
               end
            end else begin
               w_d = '0;
            end
         end
         ST_ABORT: begin
            if (!cyc_g) begin
               state_d = rr_any ? ST_OWN : ST_IDLE;
               g_d     = rr_any ? rr_idx : g_q;
               p_d     = rr_any ? rr_idx : p_q;
               w_d     = '0;
            end else begin
               w_d = 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      GNT_O   = '0;
      M_ACK_O = '0;
      M_ERR_O = '0;
      S_STB_O = 1'b0;
      S_WE_O  = 1'b0;
      S_DAT_O = '0;
      if (state_q != ST_IDLE) GNT_O[g_q] = 1'b1;
      if (state_q == ST_OWN) begin
         S_STB_O      = stb_g;
         S_WE_O       = M_WE_I[g_q];
         S_DAT_O      = M_DAT_I[{g_q, 3'b000} +: 8];
         M_ACK_O[g_q] = stb_g & S_ACK_I;
      end
      if (state_q == ST_ABORT && w_q == '0) M_ERR_O[g_q] = 1'b1;
   end

endmodule

// File: tb/tb_wbarb08.sv
// Directed scoreboard bench for wbarb08 with TMO_CYCLES=4.
module tb_wbarb08;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  cyc, stb, we;
   logic [31:0] mdat;
   logic [3:0]  ack, err, gnt;
   logic [7:0]  mdo, sdo, sdi;
   logic        sstb, swe, sack;
   logic        ack_en, ack_force;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   order[5] = '{0, 1, 2, 3, 0};

   always #5 clk = ~clk;

   // Slave model: zero-wait ACK=STB when enabled, plus a forced stray ACK.
   assign sack = ack_force | (ack_en & sstb);

   wbarb08 #(.TMO_CYCLES(4)) dut (
      .CLK_I   (clk),
      .RST_I   (rst),
      .M_CYC_I (cyc),
      .M_STB_I (stb),
      .M_WE_I  (we),
      .M_DAT_I (mdat),
      .M_ACK_O (ack),
      .M_ERR_O (err),
      .M_DAT_O (mdo),
      .GNT_O   (gnt),
      .S_STB_O (sstb),
      .S_WE_O  (swe),
      .S_DAT_O (sdo),
      .S_DAT_I (sdi),
      .S_ACK_I (sack)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic sb_check(input logic [31:0] obs);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $error("FAIL scoreboard_empty observed=%h", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   initial begin
      cyc = '0; stb = '0; we = '0; mdat = '0; sdi = '0;
      ack_en = 1'b0; ack_force = 1'b0;

      // Reset: outputs stay zero even with every master requesting.
      @(posedge clk); #1;
      cyc = 4'b1111; stb = 4'b1111; ack_en = 1'b1;
      sb_push("rst_gnt", 32'h0); sb_push("rst_stb", 32'h0);
      sb_push("rst_ack", 32'h0); sb_push("rst_err", 32'h0);
      #1;
      sb_check({28'h0, gnt}); sb_check({31'h0, sstb});
      sb_check({28'h0, ack}); sb_check({28'h0, err});
      cyc = '0; stb = '0; ack_en = 1'b0;
      rst = 1'b0;
      step();

      // Single write from master 2 against an ACK=STB slave.
      cyc = 4'b0100; stb = 4'b0100; we = 4'b0100; mdat[23:16] = 8'hA5; ack_en = 1'b1;
      sb_push("t1_gnt_c0", 32'h0);
      #1;
      sb_check({28'h0, gnt});
      sb_push("t1_gnt", 32'h4); sb_push("t1_sdat", 32'hA5);
      sb_push("t1_ack", 32'h4); sb_push("t1_swe", 32'h1);
      step();
      sb_check({28'h0, gnt}); sb_check({24'h0, sdo});
      sb_check({28'h0, ack}); sb_check({31'h0, swe});
      cyc = '0; stb = '0; we = '0;
      sb_push("t1_idle", 32'h0);
      step();
      sb_check({28'h0, gnt});

      // Fresh reset, then all four masters contend.
      rst = 1'b1; #1; rst = 1'b0;
      step();
      cyc = 4'b1111; stb = 4'b1111; we = '0;
      for (int i = 0; i < 5; i++) begin
         sb_push($sformatf("t2_gnt%0d", i), 32'(1 << order[i]));
         sb_push($sformatf("t2_ack%0d", i), 32'(1 << order[i]));
         step();
         sb_check({28'h0, gnt}); sb_check({28'h0, ack});
         if (i > 0 && i < 4) begin
            cyc[order[i-1]] = 1'b1;
            stb[order[i-1]] = 1'b1;
         end
         step();
         cyc[order[i]] = 1'b0;
         stb[order[i]] = 1'b0;
         if (i == 4) begin cyc = '0; stb = '0; end
         sb_push($sformatf("t2_dead_gnt%0d", i), 32'(1 << order[i]));
         sb_push($sformatf("t2_dead_stb%0d", i), 32'h0);
         #1;
         sb_check({28'h0, gnt}); sb_check({31'h0, sstb});
      end
      step();

      // RMW by master 1 while master 0 waits.
      sdi = 8'h77; cyc = 4'b0010; stb = 4'b0010; we = '0; mdat = '0; ack_en = 1'b1;
      sb_push("t3_rd_gnt", 32'h2); sb_push("t3_rd_ack", 32'h2);
      sb_push("t3_rd_dat", 32'h77); sb_push("t3_rd_swe", 32'h0);
      step();
      sb_check({28'h0, gnt}); sb_check({28'h0, ack});
      sb_check({24'h0, mdo}); sb_check({31'h0, swe});
      cyc[0] = 1'b1; stb[0] = 1'b1; stb[1] = 1'b0;
      sb_push("t3_gap_gnt", 32'h2); sb_push("t3_gap_ack", 32'h0);
      step();
      sb_check({28'h0, gnt}); sb_check({28'h0, ack});
      stb[1] = 1'b1; we[1] = 1'b1; mdat[15:8] = 8'h3C;
      sb_push("t3_wr_gnt", 32'h2); sb_push("t3_wr_sdat", 32'h3C);
      sb_push("t3_wr_swe", 32'h1); sb_push("t3_wr_ack", 32'h2);
      #1;
      sb_check({28'h0, gnt}); sb_check({24'h0, sdo});
      sb_check({31'h0, swe}); sb_check({28'h0, ack});
      step();
      cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
      sb_push("t3_rel_gnt", 32'h2);
      #1;
      sb_check({28'h0, gnt});
      sb_push("t3_m0_gnt", 32'h1); sb_push("t3_m0_ack", 32'h1);
      step();
      sb_check({28'h0, gnt}); sb_check({28'h0, ack});
      cyc = '0; stb = '0;
      step();

      // Timeout with a slave that never acknowledges.
      ack_en = 1'b0; sdi = '0;
      cyc = 4'b0100; stb = 4'b0100; we = 4'b0100;
      step();
      for (int k = 0; k < 4; k++) begin
         sb_push($sformatf("t4_stb%0d", k), 32'h1);
         sb_push($sformatf("t4_err%0d", k), 32'h0);
         #1;
         sb_check({31'h0, sstb}); sb_check({28'h0, err});
         step();
      end
      sb_push("t4_err_pulse", 32'h4); sb_push("t4_stb_off", 32'h0);
      sb_push("t4_gnt_keep", 32'h4);
      sb_check({28'h0, err}); sb_check({31'h0, sstb}); sb_check({28'h0, gnt});
      ack_force = 1'b1;
      sb_push("t4_stray_ack", 32'h0);
      #1;
      sb_check({28'h0, ack});
      ack_force = 1'b0;
      sb_push("t4_err_once", 32'h0); sb_push("t4_stb_off2", 32'h0);
      sb_push("t4_gnt_keep2", 32'h4);
      step();
      sb_check({28'h0, err}); sb_check({31'h0, sstb}); sb_check({28'h0, gnt});
      cyc = '0; stb = '0; we = '0;
      sb_push("t4_rel_gnt", 32'h0);
      step();
      sb_check({28'h0, gnt});

      // Asynchronous reset in the middle of a transfer.
      ack_en = 1'b1;
      cyc = 4'b0010; stb = 4'b0010;
      sb_push("t5_gnt", 32'h2); sb_push("t5_ack", 32'h2); sb_push("t5_stb", 32'h1);
      step();
      sb_check({28'h0, gnt}); sb_check({28'h0, ack}); sb_check({31'h0, sstb});
      #2;
      rst = 1'b1;
      sb_push("t5_rst_gnt", 32'h0); sb_push("t5_rst_stb", 32'h0); sb_push("t5_rst_ack", 32'h0);
      #1;
      sb_check({28'h0, gnt}); sb_check({31'h0, sstb}); sb_check({28'h0, ack});
      #1;
      rst = 1'b0;
      cyc = 4'b1111; stb = '0;
      sb_push("t5_first_gnt", 32'h1);
      step();
      sb_check({28'h0, gnt});

      // Master 3 strobes without a grant while master 0 owns the bus.
      cyc = 4'b1001; stb = 4'b1001; we = 4'b1000;
      mdat = '0; mdat[7:0] = 8'h11; mdat[31:24] = 8'hEE;
      sb_push("t6_swe", 32'h0); sb_push("t6_sdat", 32'h11);
      sb_push("t6_ack", 32'h1); sb_push("t6_gnt", 32'h1);
      #1;
      sb_check({31'h0, swe}); sb_check({24'h0, sdo});
      sb_check({28'h0, ack}); sb_check({28'h0, gnt});
      cyc = '0; stb = '0; we = '0;
      step();
      step();

      if (sb.size() != 0) begin
         total++;
         bad++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
